// File: rtl/melody_match_controller.sv
// Melody exercise sequencer. Holds up to max_len target notes, follows the
// recognizer's note stream, and reports progress, hit pulses and pass/fail.
module melody_match_controller #(
  parameter int max_len        = 8,
  parameter int timeout_cycles = 150_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load_vld,
  input  logic [3:0]                   load_idx,
  input  logic                         start,
  input  logic                         note_vld,
  input  logic [3:0]                   note_idx,
  output logic                         busy,
  output logic [$clog2(max_len+1)-1:0] len,
  output logic [$clog2(max_len)-1:0]   step,
  output logic [3:0]                   target_idx,
  output logic                         hit,
  output logic                         done,
  output logic                         pass
);
  localparam int LW = $clog2(max_len + 1);
  localparam int SW = $clog2(max_len);
  localparam int TW = $clog2(timeout_cycles);

  typedef enum logic [1:0] {S_IDLE, S_LISTEN, S_PASS, S_FAIL} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   len_n;
  logic [SW-1:0]   step_n;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0]      target_n;
  logic            hit_n;
  logic            wr_en;
  logic [SW-1:0]   wr_addr;
  logic [3:0]      mem [max_len];

  logic            prev_vld;
  logic [3:0]      prev_idx;
  logic            ev_q;
  logic [3:0]      ev_idx;

  assign wr_addr = len[SW-1:0];

  // Edge detector on the recognizer stream: a new press or a change of note
  // is an event. The event is registered so the FSM sees it one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld <= 1'b0;
      prev_idx <= 4'd0;
      ev_q     <= 1'b0;
      ev_idx   <= 4'd0;
    end else begin
      prev_vld <= note_vld;
      prev_idx <= note_idx;
      ev_q     <= note_vld && (!prev_vld || (note_idx != prev_idx));
      ev_idx   <= note_idx;
    end
  end

  // Melody storage; contents need no reset because len gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= load_idx;
  end

  // Next-state logic: clear beats start, start beats loading.
  always_comb begin
    state_n  = state;
    len_n    = len;
    step_n   = step;
    timer_n  = timer;
    hit_n    = 1'b0;
    wr_en    = 1'b0;
    target_n = 4'd0;
    if (clear) begin
      state_n = S_IDLE;
      len_n   = '0;
      step_n  = '0;
      timer_n = '0;
    end else if (start && ((state != S_IDLE) || (len != '0))) begin
      state_n = S_LISTEN;
      step_n  = '0;
      timer_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_vld && (load_idx <= 4'd11) && (len < LW'(max_len))) begin
            wr_en = 1'b1;
            len_n = len + LW'(1);
          end
        end
        S_LISTEN: begin
          timer_n = timer + TW'(1);
          if (ev_q) begin
            if (ev_idx == mem[step]) begin
              hit_n = 1'b1;
              if (LW'(step) == (len - LW'(1))) begin
                state_n = S_PASS;
              end else begin
                step_n  = step + SW'(1);
                timer_n = '0;
              end
            end else begin
              state_n = S_FAIL;
            end
          end else if (timer == TW'(timeout_cycles - 1)) begin
            state_n = S_FAIL;
          end
        end
        default: ;
      endcase
    end
    // Target lookup for the registered output, bypassing a same-cycle write.
    if (len_n == '0)
      target_n = 4'd0;
    else if (wr_en && (wr_addr == step_n))
      target_n = load_idx;
    else
      target_n = mem[step_n];
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      step       <= '0;
      timer      <= '0;
      target_idx <= 4'd0;
      hit        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      step       <= step_n;
      timer      <= timer_n;
      target_idx <= target_n;
      hit        <= hit_n;
      busy       <= (state_n == S_LISTEN);
      done       <= (state_n == S_PASS) || (state_n == S_FAIL);
      pass       <= (state_n == S_PASS);
    end
  end

endmodule

// File: tb/tb_melody_match_controller.sv
// Bench for melody_match_controller: directed scenarios plus random episodes,
// checked cycle by cycle against a queue-based behavioural model.
module tb_melody_match_controller;
  localparam int MAXL = 8;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst, clear, load_vld, start, note_vld;
  logic [3:0] load_idx, note_idx;
  logic       busy, hit, done, pass;
  logic [3:0] len;
  logic [2:0] step;
  logic [3:0] target_idx;

  melody_match_controller #(.max_len(MAXL), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_vld(load_vld), .load_idx(load_idx),
    .start(start), .note_vld(note_vld), .note_idx(note_idx),
    .busy(busy), .len(len), .step(step), .target_idx(target_idx),
    .hit(hit), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [14:0] expq [$];

  // Behavioural model: melody as a queue, position, cycles waited on the
  // current note, and the phase of the exercise.
  localparam int P_IDLE = 0, P_LISTEN = 1, P_PASS = 2, P_FAIL = 3;
  int mel [$];
  int pos, waited, phase;
  bit m_hit;
  bit last_vld;
  int last_idx;
  bit pend;
  int pend_note;

  task automatic model_step();
    bit cur_ev;
    int cur_note;
    if (rst) begin
      mel.delete();
      pos = 0; waited = 0; phase = P_IDLE; m_hit = 0;
      last_vld = 0; last_idx = 0; pend = 0; pend_note = 0;
      return;
    end
    m_hit    = 0;
    cur_ev   = pend;
    cur_note = pend_note;
    pend      = note_vld && (!last_vld || int'(note_idx) != last_idx);
    pend_note = int'(note_idx);
    last_vld  = note_vld;
    last_idx  = int'(note_idx);
    if (clear) begin
      mel.delete(); pos = 0; waited = 0; phase = P_IDLE;
    end else if (start && (phase != P_IDLE || mel.size() > 0)) begin
      phase = P_LISTEN; pos = 0; waited = 0;
    end else if (phase == P_IDLE) begin
      if (load_vld && load_idx <= 11 && mel.size() < MAXL) mel.push_back(int'(load_idx));
    end else if (phase == P_LISTEN) begin
      if (cur_ev) begin
        if (cur_note == mel[pos]) begin
          m_hit = 1;
          if (pos == mel.size() - 1) phase = P_PASS;
          else begin pos++; waited = 0; end
        end else phase = P_FAIL;
      end else begin
        waited++;
        if (waited == TO) phase = P_FAIL;
      end
    end
  endtask

  function automatic logic [14:0] model_out();
    logic [3:0] tgt;
    tgt = (mel.size() > 0) ? 4'(mel[pos]) : 4'd0;
    return {phase == P_LISTEN, 4'(mel.size()), 3'(pos), tgt, m_hit,
            phase == P_PASS || phase == P_FAIL, phase == P_PASS};
  endfunction

  // Monitor: compares every registered output snapshot with the model.
  always @(posedge clk) begin : mon
    logic [14:0] e, a;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {busy, len, step, target_idx, hit, done, pass};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t: got busy=%b len=%0d step=%0d tgt=%0d hit=%b done=%b pass=%b, want busy=%b len=%0d step=%0d tgt=%0d hit=%b done=%b pass=%b",
                 $time, a[14], a[13:10], a[9:7], a[6:3], a[2], a[1], a[0],
                 e[14], e[13:10], e[9:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic cyc();
    model_step();
    expq.push_back(model_out());
    @(negedge clk);
    clear = 0; load_vld = 0; start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic load(input int idx);
    load_vld = 1; load_idx = 4'(idx); cyc();
  endtask

  task automatic do_start();
    start = 1; cyc();
  endtask

  task automatic do_clear();
    clear = 1; cyc();
  endtask

  task automatic press(input int idx, input int hold);
    note_vld = 1; note_idx = 4'(idx);
    repeat (hold) cyc();
    note_vld = 0;
    cyc();
  endtask

  initial begin
    rst = 1; clear = 0; load_vld = 0; load_idx = 0; start = 0; note_vld = 0; note_idx = 0;
    cyc(); cyc();
    rst = 0;

    // C E G melody, played correctly then with a wrong second note
    load(0); load(4); load(7);
    do_start();
    press(0, 2); press(4, 2); press(7, 2); idle(3);
    do_start();
    press(0, 2); press(2, 2); idle(3);

    // single note: timeout, and events right around the timeout boundary
    do_clear(); load(5); do_start(); idle(105);
    for (int k = 97; k <= 99; k++) begin
      do_start(); idle(k); press(5, 1); idle(3);
    end

    // note held across start is not an event
    do_clear(); load(0);
    note_vld = 1; note_idx = 0; idle(3);
    do_start(); idle(105);
    do_start(); idle(2);
    note_vld = 0; cyc();
    press(0, 2); idle(3);

    // overfill, out-of-range load, clear+start together
    do_clear();
    for (int i = 0; i < 9; i++) load(i);
    load(12); idle(2);
    clear = 1; start = 1; cyc(); idle(2);

    // repeated note needs a release; reset mid-exercise
    load(5); load(5); do_start();
    note_vld = 1; note_idx = 5; idle(6);
    idle(100);
    note_vld = 0; cyc();
    do_start(); press(5, 1); idle(3);
    rst = 1; cyc(); rst = 0; idle(3);

    // random episodes
    for (int e = 0; e < 40; e++) begin
      int n;
      do_clear();
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++)
        load(($urandom_range(0, 9) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11));
      do_start();
      for (int j = 0; j < mel.size(); j++) begin
        int r, nt;
        r  = $urandom_range(0, 24);
        nt = (phase == P_LISTEN) ? mel[pos] : $urandom_range(0, 11);
        if (r == 0) nt = (nt + 1) % 12;
        if (r == 1) nt = 13;
        if (r == 2) idle(TO - 3 + $urandom_range(0, 6));
        if (r == 3) do_start();
        if (r == 4) load($urandom_range(0, 11));
        press(nt, $urandom_range(1, 4));
        idle($urandom_range(0, 3));
      end
      idle(3);
      if ($urandom_range(0, 7) == 0) begin rst = 1; cyc(); rst = 0; end
    end

    @(posedge clk); #2;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
